// File: rtl/arb_pkg.sv
// Shared state encoding and default sizing for the memory port arbiter.
package arb_pkg;

    localparam int ADDR_W_DEF     = 32;
    localparam int DATA_W_DEF     = 32;
    localparam int MAX_STARVE_DEF = 3;
    localparam int TIMEOUT_DEF    = 255;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_WAIT = 2'd1,
        D_WAIT  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, data first with starvation relief.
// Latency: request sampled in IDLE -> mem_req next cycle; *_valid one cycle after mem_ready (or timeout).
// Backpressure: requesters hold while *_stall is high; memory side paced by mem_ready, bounded by TIMEOUT.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MAX_STARVE = MAX_STARVE_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err
);

    localparam int SW = (MAX_STARVE < 1) ? 1 : $clog2(MAX_STARVE + 1);
    localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

    arb_state_t        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_valid_q, if_valid_d;
    logic              d_valid_q, d_valid_d;
    logic              err_q, err_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic              grant_if, grant_d, done, timeout;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_valid_d  = 1'b0;
        d_valid_d   = 1'b0;
        err_d       = 1'b0;
        starve_d    = starve_q;
        wait_d      = wait_q;
        done        = 1'b0;
        timeout     = 1'b0;
        grant_if    = if_req & (~d_req | (starve_q == STARVE_MAX));
        grant_d     = d_req & ~grant_if;

        case (state_q)
            IDLE: begin
                wait_d = '0;
                if (grant_if) begin
                    state_d    = IF_WAIT;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                end else if (grant_d) begin
                    state_d     = D_WAIT;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                end
            end
            IF_WAIT, D_WAIT: begin
                if (mem_ready) begin
                    done = 1'b1;
                end else if (wait_q == WAIT_LAST) begin
                    done    = 1'b1;
                    timeout = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        // A timed-out access still completes towards its owner, but leaves rdata untouched.
        if (done) begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
            wait_d    = '0;
            err_d     = timeout;
            if (state_q == IF_WAIT) begin
                if_valid_d = 1'b1;
                if (!timeout) if_rdata_d = mem_rdata;
            end else begin
                d_valid_d = 1'b1;
                if (!timeout && !mem_we_q) d_rdata_d = mem_rdata;
            end
        end

        if (!if_req) begin
            starve_d = '0;
        end else if (state_q == IDLE && grant_if) begin
            starve_d = '0;
        end else if (state_q == IDLE && grant_d && starve_q != STARVE_MAX) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            err_q       <= 1'b0;
            starve_q    <= '0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_valid_q  <= if_valid_d;
            d_valid_q   <= d_valid_d;
            err_q       <= err_d;
            starve_q    <= starve_d;
            wait_q      <= wait_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_valid  = if_valid_q;
    assign d_valid   = d_valid_q;
    assign err       = err_q;
    assign if_stall  = if_req & ~if_valid_q;
    assign d_stall   = d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, corner-case sequences, then
// randomized fetch/data traffic against a transaction-level memory reference.
module tb_mem_port_arbiter;

    localparam int MS = 3;
    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we, mem_ready;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_valid, if_stall, d_valid, d_stall, mem_req, mem_we, err;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_STARVE(MS), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .err(err)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory device: lat_fixed < 0 random 1..4 cycles, 0 never ready, N fixed.
    logic [31:0] dev_mem [logic [31:0]];
    int lat_fixed = 1;

    initial begin : device
        int dev_cnt, dev_lat;
        mem_ready = 1'b0;
        mem_rdata = '0;
        dev_cnt = 0;
        dev_lat = 1;
        forever begin
            @(negedge clk);
            if (mem_req && !mem_ready) begin
                if (dev_cnt == 0) dev_lat = (lat_fixed < 0) ? int'($urandom_range(1, 4)) : lat_fixed;
                dev_cnt++;
                if (lat_fixed != 0 && dev_cnt >= dev_lat) begin
                    mem_ready = 1'b1;
                    if (mem_we) dev_mem[mem_addr] = mem_wdata;
                    else mem_rdata = dev_mem.exists(mem_addr) ? dev_mem[mem_addr] : init_val(mem_addr);
                end
            end else begin
                mem_ready = 1'b0;
                dev_cnt = 0;
            end
        end
    end

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] exp_rdata;
        int          exp_k;
    } vec_t;
    vec_t vecs[8];

    task automatic run_vec(input vec_t v, input int idx);
        int k, hold_bad;
        logic vld;
        string nm;
        nm = $sformatf("vec%0d", idx);
        @(negedge clk);
        lat_fixed = v.lat;
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        #1;
        check({nm, "_stall_before_grant"}, v.is_d ? d_stall : if_stall, 1'b1);
        @(posedge clk); #1;
        check({nm, "_grant"}, {mem_req, mem_we, mem_addr}, {1'b1, v.we, v.addr});
        if (v.we) check({nm, "_wdata"}, mem_wdata, v.wdata);
        k = 0;
        hold_bad = 0;
        do begin
            @(posedge clk); #1;
            k++;
            vld = v.is_d ? d_valid : if_valid;
            if (!vld && ({mem_req, mem_we, mem_addr} !== {1'b1, v.we, v.addr} ||
                         (v.we && mem_wdata !== v.wdata))) hold_bad++;
        end while (!vld && k < 300);
        check({nm, "_valid_cycle"}, k, v.exp_k);
        check({nm, "_hold_stable"}, hold_bad, 0);
        check({nm, "_mem_req_dropped"}, mem_req, 1'b0);
        check({nm, "_rdata"}, v.is_d ? d_rdata : if_rdata, v.exp_rdata);
        check({nm, "_stall_at_valid"}, v.is_d ? d_stall : if_stall, 1'b0);
        check({nm, "_no_err"}, err, 1'b0);
        @(negedge clk);
        if (v.is_d) d_req = 1'b0; else if_req = 1'b0;
        @(posedge clk); #1;
        check({nm, "_valid_one_cycle"}, {if_valid, d_valid, mem_req}, 3'b000);
    endtask

    task automatic wait_valid(input bit is_d, input string nm, input int limit, output int k);
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!(is_d ? d_valid : if_valid) && k < limit);
        check({nm, "_valid_seen"}, is_d ? d_valid : if_valid, 1'b1);
    endtask

    task automatic test_contention();
        int t;
        @(negedge clk);
        lat_fixed = 1;
        if_req = 1'b1; if_addr = 32'h20;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        @(posedge clk); #1;
        check("cont_data_first", {mem_req, mem_addr}, {1'b1, 32'h100});
        check("cont_if_stall", if_stall, 1'b1);
        wait_valid(1'b1, "cont_d", 20, t);
        check("cont_d_rdata", d_rdata, 32'h5A5A_0100);
        check("cont_if_stall_at_dvalid", if_stall, 1'b1);
        @(negedge clk);
        d_req = 1'b0;
        @(posedge clk); #1;
        check("cont_fetch_next_idle", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h20});
        wait_valid(1'b0, "cont_if", 20, t);
        check("cont_if_rdata", if_rdata, 32'h5A5A_0020);
        @(negedge clk);
        if_req = 1'b0;
    endtask

    task automatic test_starve();
        logic [3:0] seq;
        int g, t;
        logic prev;
        @(negedge clk);
        lat_fixed = 1;
        if_req = 1'b1; if_addr = 32'h1000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        seq = '0; g = 0; t = 0; prev = mem_req;
        while (g < 4 && t < 100) begin
            @(posedge clk); #1;
            t++;
            if (mem_req && !prev) begin
                seq = {seq[2:0], mem_addr == 32'h200};
                g++;
            end
            prev = mem_req;
        end
        check("starve_order_DDDI", seq, 4'b1110);
        @(negedge clk);
        d_req = 1'b0;
        wait_valid(1'b0, "starve_if", 20, t);
        check("starve_if_rdata", if_rdata, 32'h5A5A_1000);
        @(negedge clk);
        if_req = 1'b0;
        @(posedge clk); #1;
        check("starve_dropped_req_ignored", mem_req, 1'b0);
    endtask

    task automatic test_timeout();
        int k, lost;
        @(negedge clk);
        lat_fixed = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h104;
        @(posedge clk); #1;
        k = 0; lost = 0;
        do begin
            @(posedge clk); #1;
            k++;
            if (!err && !d_valid && !mem_req) lost++;
        end while (!err && !d_valid && k < 400);
        check("tmo_cycles", k, TO);
        check("tmo_req_held", lost, 0);
        check("tmo_err_valid", {err, d_valid, mem_req}, 3'b110);
        check("tmo_rdata_unchanged", d_rdata, 32'h5A5A_0200);
        @(negedge clk);
        d_req = 1'b0;
        @(posedge clk); #1;
        check("tmo_single_pulse", {err, d_valid}, 2'b00);
    endtask

    task automatic test_reset_mid();
        int dv;
        @(negedge clk);
        lat_fixed = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h108;
        repeat (3) @(posedge clk);
        #2;
        check("rst_mid_busy", mem_req, 1'b1);
        reset = 1'b1;
        #1;
        check("rst_mid_req_async", mem_req, 1'b0);
        check("rst_mid_regs_clear", {mem_addr, d_rdata}, 64'h0);
        check("rst_mid_if_rdata_clear", if_rdata, 32'h0);
        @(negedge clk);
        d_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        dv = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (d_valid || mem_req) dv++;
        end
        check("rst_mid_no_valid", dv, 0);
    endtask

    // Reference model: ref_mem tracks architectural memory seen by the data port.
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] last_d;
    bit mon_en = 1'b0;

    task automatic rand_fetch(input int n);
        for (int i = 0; i < n; i++) begin
            int gap, t;
            logic [31:0] a;
            gap = $urandom_range(0, 2);
            a = 32'h1000 + ($urandom_range(0, 15) << 2);
            repeat (gap) begin if_req = 1'b0; @(negedge clk); end
            if_req = 1'b1; if_addr = a;
            t = 0;
            do begin @(negedge clk); t++; end while (!if_valid && t < 200);
            check("rnd_if_valid", if_valid, 1'b1);
            check("rnd_if_rdata", if_rdata, init_val(a));
        end
        if_req = 1'b0;
    endtask

    task automatic rand_data(input int n);
        for (int i = 0; i < n; i++) begin
            int gap, t;
            logic [31:0] a, wd, exp_rd;
            logic we;
            gap = $urandom_range(0, 2);
            a = 32'h100 + ($urandom_range(0, 7) << 2);
            wd = $urandom;
            we = 1'($urandom_range(0, 1));
            repeat (gap) begin d_req = 1'b0; @(negedge clk); end
            d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
            t = 0;
            do begin @(negedge clk); t++; end while (!d_valid && t < 200);
            check("rnd_d_valid", d_valid, 1'b1);
            if (we) begin
                check("rnd_d_write_keeps_rdata", d_rdata, last_d);
                ref_mem[a] = wd;
            end else begin
                exp_rd = ref_mem.exists(a) ? ref_mem[a] : init_val(a);
                check("rnd_d_read", d_rdata, exp_rd);
                last_d = exp_rd;
            end
        end
        d_req = 1'b0;
    endtask

    initial begin : monitor
        logic prev_req, owner_d, s_we, rise, exp_rise, gfetch, exp_fetch, done;
        logic [31:0] s_addr, s_wdata;
        int streak;
        prev_req = 1'b0; owner_d = 1'b0; s_we = 1'b0;
        s_addr = '0; s_wdata = '0; streak = 0;
        forever begin
            @(posedge clk); #1;
            if (mon_en) begin
                done = prev_req && mem_ready;
                check("mon_if_valid", if_valid, done && !owner_d);
                check("mon_d_valid", d_valid, done && owner_d);
                check("mon_err", err, 1'b0);
                if (done) check("mon_req_drop", mem_req, 1'b0);
                rise = mem_req && !prev_req;
                exp_rise = !prev_req && (if_req || d_req);
                check("mon_grant_taken", rise, exp_rise);
                if (rise) begin
                    gfetch = (mem_addr >= 32'h1000);
                    exp_fetch = if_req && (!d_req || streak == MS);
                    check("mon_priority", gfetch, exp_fetch);
                    owner_d = !gfetch;
                    check("mon_grant_addr", mem_addr, gfetch ? if_addr : d_addr);
                    check("mon_grant_we", mem_we, gfetch ? 1'b0 : d_we);
                    if (!gfetch && d_we) check("mon_grant_wdata", mem_wdata, d_wdata);
                    s_addr = mem_addr; s_we = mem_we; s_wdata = mem_wdata;
                    if (!if_req || gfetch) streak = 0;
                    else streak = (streak < MS) ? streak + 1 : MS;
                end else begin
                    if (!if_req) streak = 0;
                    if (mem_req) begin
                        check("mon_hold_addr_we", {mem_we, mem_addr}, {s_we, s_addr});
                        if (s_we) check("mon_hold_wdata", mem_wdata, s_wdata);
                    end
                end
                check("mon_if_stall", if_stall, if_req && !if_valid);
                check("mon_d_stall", d_stall, d_req && !d_valid);
            end
            prev_req = mem_req;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        dev_mem[32'h10] = 32'h2002_0005;

        //          is_d we  addr         wdata          lat exp_rdata      exp_k
        vecs[0] = '{1'b0, 1'b0, 32'h10,  32'h0,          1, 32'h2002_0005, 1};
        vecs[1] = '{1'b1, 1'b0, 32'h100, 32'h0,          2, 32'h5A5A_0100, 2};
        vecs[2] = '{1'b1, 1'b1, 32'h40,  32'hDEAD_BEEF,  3, 32'h5A5A_0100, 3};
        vecs[3] = '{1'b1, 1'b0, 32'h40,  32'h0,          1, 32'hDEAD_BEEF, 1};
        vecs[4] = '{1'b0, 1'b0, 32'h24,  32'h0,          4, 32'h5A5A_0024, 4};
        vecs[5] = '{1'b0, 1'b0, 32'h10,  32'h0,          2, 32'h2002_0005, 2};
        vecs[6] = '{1'b0, 1'b0, 32'h28,  32'h0,          1, 32'h5A5A_0028, 1};
        vecs[7] = '{1'b1, 1'b0, 32'h10C, 32'h0,          2, 32'h5A5A_010C, 2};

        #12;
        check("reset_ctrl", {mem_req, mem_we, if_valid, d_valid, err}, 5'b00000);
        check("reset_mem_bus", {mem_addr, mem_wdata}, 64'h0);
        check("reset_rdata", {if_rdata, d_rdata}, 64'h0);
        check("reset_stalls", {if_stall, d_stall}, 2'b00);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);
        test_contention();
        test_starve();
        test_timeout();
        run_vec(vecs[6], 6);
        test_reset_mid();
        run_vec(vecs[7], 7);

        @(negedge clk);
        lat_fixed = -1;
        last_d = 32'h5A5A_010C;
        mon_en = 1'b1;
        fork
            rand_fetch(60);
            rand_data(60);
        join
        repeat (3) @(negedge clk);
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 32, address width; DATA_W, default 32, data width; MAX_STARVE, default 3, consecutive data grants allowed while a fetch waits; TIMEOUT, default 255, cycles allowed before mem_ready.
REQ-002 Reset and clock SHALL be: reset, asynchronous, active-high; clock clk.
REQ-003 Ports SHALL be, as name, direction, width, meaning:
- clk in 1 clock
- reset in 1 async active-high reset
- if_req in 1 fetch request, held until if_valid
- if_addr in ADDR_W fetch address
- if_rdata out DATA_W fetched instruction, registered
- if_valid out 1 one-cycle fetch-complete pulse
- if_stall out 1 fetch stage must hold
- d_req in 1 data request, held until d_valid
- d_we in 1 data write (1) / read (0)
- d_addr in ADDR_W data address
- d_wdata in DATA_W store data
- d_rdata out DATA_W load data, registered
- d_valid out 1 one-cycle data-complete pulse
- d_stall out 1 MEM stage must hold
- mem_req out 1 memory access strobe, registered
- mem_we out 1 memory write enable, registered
- mem_addr out ADDR_W memory address, registered
- mem_wdata out DATA_W memory write data, registered
- mem_rdata in DATA_W memory read data, valid with mem_ready
- mem_ready in 1 memory access complete
- err out 1 one-cycle timeout pulse

Function
REQ-004 FSM SHALL have states IDLE, IF_WAIT, D_WAIT.
REQ-005 In IDLE with any request, the arbiter SHALL grant, latch address/we/wdata into mem_* registers, and assert mem_req from the next cycle.
REQ-006 Grant priority SHALL be data over fetch, except fetch wins when starve_cnt == MAX_STARVE.
REQ-007 starve_cnt SHALL increment (saturating at MAX_STARVE) on each data grant while if_req is high, and SHALL clear on a fetch grant or whenever if_req is low.
REQ-008 In IF_WAIT/D_WAIT, mem_req, mem_we, mem_addr and mem_wdata SHALL stay stable until the cycle mem_ready is sampled high.
REQ-009 On mem_ready: mem_req SHALL drop next cycle; FSM SHALL return to IDLE; the owner's valid SHALL pulse for exactly one cycle next cycle; mem_rdata SHALL be captured into if_rdata (fetch) or d_rdata (data read).
REQ-010 A data write SHALL pulse d_valid and leave d_rdata unchanged; mem_we SHALL be 0 for all fetches.
REQ-011 Minimum latency SHALL be: request sampled in IDLE at cycle N, mem_req high at N+1, mem_ready at N+1 gives valid at N+2; at most one access per two cycles.
REQ-012 if_stall SHALL equal if_req & ~if_valid; d_stall SHALL equal d_req & ~d_valid (combinational).
REQ-013 A wait counter SHALL count cycles in IF_WAIT/D_WAIT; at TIMEOUT without mem_ready, the arbiter SHALL drop mem_req, pulse err once, pulse the owner's valid with rdata unchanged, and return to IDLE.
REQ-014 Simultaneous if_req and d_req in IDLE SHALL follow REQ-006; the loser SHALL stay stalled and be granted at the next IDLE.
REQ-015 Requests that deassert while not granted SHALL be ignored without side effects.

Reset
REQ-016 On reset, the arbiter SHALL force state IDLE, and clear mem_req, mem_we, if_valid, d_valid, err, starve_cnt and the wait counter to 0.
REQ-017 On reset, mem_addr, mem_wdata, if_rdata and d_rdata SHALL clear to 0.
REQ-018 Reset asserted mid-access SHALL drop mem_req asynchronously, and the pending access SHALL never report valid.

Structure
REQ-019 Package arb_pkg SHALL hold the state enum arb_state_t and the default constants for ADDR_W, DATA_W, MAX_STARVE and TIMEOUT.
REQ-020 The design SHALL be a single module with no sub-module; starve and wait counters are inline.

Verification
REQ-021 Fetch only: if_req=1, if_addr=0x10, ready after 1 cycle, rdata=0x2002_0005 -> mem_req cycles 1..1, if_valid at cycle 2, if_rdata=0x2002_0005.
REQ-022 Contention: if_req and d_req (read, 0x100) both high -> data granted first, if_stall held, fetch granted at next IDLE.
REQ-023 Starvation: if_req held with d_req continuously high for 4 accesses -> grants D,D,D,IF.
REQ-024 Store: d_we=1, d_addr=0x40, d_wdata=0xDEAD_BEEF -> mem_we=1 with those values stable through 3 wait cycles, d_valid pulse, d_rdata unchanged.
REQ-025 Timeout: mem_ready never asserted -> err and owner valid pulse after TIMEOUT=255 wait cycles, mem_req low, state IDLE.
REQ-026 Reset mid-access: reset during D_WAIT -> mem_req=0 immediately, no d_valid, next request is served normally.
